// File: rtl/disp_scan_bcd.sv
// Four-digit display front end: sequential double-dabble binary-to-BCD conversion
// feeding a refresh-multiplexed nibble bus with active-low anodes and leading-zero blanking.
module disp_scan_bcd #(
  parameter int REFRESH_CNT = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Value,
  input  logic        Load,
  output logic        Busy,
  output logic        Ovf,
  output logic [3:0]  Digit,
  output logic [3:0]  An
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_bin;
  logic [15:0] r_bcd;
  logic [15:0] r_disp;
  logic [3:0]  r_iter;
  logic        r_ovf_pend;
  logic        r_busy;
  logic        r_ovf;
  logic [15:0] r_refresh;
  logic [1:0]  r_idx;
  logic [3:0]  r_digit;
  logic [3:0]  r_an;

  logic [15:0] w_bcd_adj;
  logic [1:0]  w_idx_nxt;
  logic [3:0]  w_digit_nxt;
  logic [3:0]  w_an_nxt;
  logic        w_upper_zero;
  logic        w_wrap;

  function automatic logic [15:0] f_dd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Double-dabble correction and next scan slot selection
  always_comb begin
    w_bcd_adj    = f_dd_adjust(r_bcd);
    w_wrap       = (r_refresh == 16'(REFRESH_CNT - 1));
    w_idx_nxt    = r_idx + 2'd1;
    w_digit_nxt  = 4'h0;
    w_upper_zero = 1'b0;
    case (w_idx_nxt)
      2'd0: begin w_digit_nxt = r_disp[3:0];   w_upper_zero = 1'b0; end
      2'd1: begin w_digit_nxt = r_disp[7:4];   w_upper_zero = (r_disp[15:4] == 12'h000); end
      2'd2: begin w_digit_nxt = r_disp[11:8];  w_upper_zero = (r_disp[15:8] == 8'h00); end
      2'd3: begin w_digit_nxt = r_disp[15:12]; w_upper_zero = (r_disp[15:12] == 4'h0); end
      default: begin w_digit_nxt = 4'h0; w_upper_zero = 1'b0; end
    endcase
    if ((LZ_BLANK != 0) && !r_ovf && w_upper_zero) begin
      w_an_nxt = 4'b1111;
    end else begin
      w_an_nxt = ~(4'b0001 << w_idx_nxt);
    end
  end

  // Conversion FSM: capture, 16 shift steps, then commit to the display register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_bin      <= 16'h0000;
      r_bcd      <= 16'h0000;
      r_iter     <= 4'd0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_disp     <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Load) begin
            r_bin      <= Value;
            r_bcd      <= 16'h0000;
            r_iter     <= 4'd0;
            r_ovf_pend <= (Value > 16'd9999);
            r_busy     <= 1'b1;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
          r_iter         <= r_iter + 4'd1;
          if (r_iter == 4'd15) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // Out-of-range values show the non-numeric code on every digit
          r_disp  <= r_ovf_pend ? 16'hFFFF : r_bcd;
          r_ovf   <= r_ovf_pend;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Free-running refresh counter and scan outputs, updated together on wrap
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_refresh <= 16'h0000;
      r_idx     <= 2'd0;
      r_digit   <= 4'h0;
      r_an      <= 4'b1110;
    end else if (w_wrap) begin
      r_refresh <= 16'h0000;
      r_idx     <= w_idx_nxt;
      r_digit   <= w_digit_nxt;
      r_an      <= w_an_nxt;
    end else begin
      r_refresh <= r_refresh + 16'd1;
    end
  end

  assign Busy  = r_busy;
  assign Ovf   = r_ovf;
  assign Digit = r_digit;
  assign An    = r_an;

endmodule

// File: tb/tb_disp_scan_bcd.sv
// Scoreboard bench for disp_scan_bcd: stimulus queues loaded values, a monitor
// checks commit timing, overflow and every scanned Digit/An pair against a decimal model.
module tb_disp_scan_bcd;

  localparam int RC = 4;

  logic        Clk;
  logic        Rst;
  logic [15:0] Value;
  logic        Load;
  logic        Busy1, Ovf1, Busy0, Ovf0;
  logic [3:0]  Digit1, An1, Digit0, An0;

  disp_scan_bcd #(.REFRESH_CNT(RC), .LZ_BLANK(1)) u_dut_lz (
    .Clk(Clk), .Rst(Rst), .Value(Value), .Load(Load),
    .Busy(Busy1), .Ovf(Ovf1), .Digit(Digit1), .An(An1)
  );

  disp_scan_bcd #(.REFRESH_CNT(RC), .LZ_BLANK(0)) u_dut_nz (
    .Clk(Clk), .Rst(Rst), .Value(Value), .Load(Load),
    .Busy(Busy0), .Ovf(Ovf0), .Digit(Digit0), .An(An0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;
  int sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Decimal model of one display slot: returns {digit, anodes}
  function automatic int exp_pair(input int v, input int lz, input int slot);
    int p;
    logic [3:0] d;
    logic [3:0] a;
    p = 1;
    for (int i = 0; i < slot; i++) p = p * 10;
    a = ~(4'b0001 << slot);
    if (v > 9999) begin
      d = 4'hF;
    end else begin
      d = 4'((v / p) % 10);
      if (lz != 0 && slot > 0 && v < p) a = 4'b1111;
    end
    return int'({d, a});
  endfunction

  // Monitor / scoreboard
  bit started = 0;
  bit rst_now;
  bit prev_busy = 0;
  int n_cyc, slot, shown, committed, busy_cnt, e;

  initial begin : monitor
    forever begin
      @(posedge Clk);
      rst_now = Rst;
      if (Rst) begin
        started = 1; n_cyc = 0; slot = 0; shown = 0; committed = 0;
        busy_cnt = 0; prev_busy = 0;
        sb.delete();
      end else if (started) begin
        n_cyc++;
        if (n_cyc % RC == 0) begin
          slot  = (slot + 1) % 4;
          shown = committed;
        end
      end
      @(negedge Clk);
      if (started) begin
        if (rst_now) begin
          check("rst_busy", int'(Busy1), 0);
          check("rst_ovf", int'(Ovf1), 0);
        end else begin
          if (prev_busy && !Busy1) begin
            if (sb.size() == 0) begin
              n_total++;
              $display("FAIL commit_unexpected: got commit expected none at %0t", $time);
            end else begin
              e = sb.pop_front();
              check("busy_len", busy_cnt, 17);
              check("ovf_lz", int'(Ovf1), int'(e > 9999));
              check("ovf_nz", int'(Ovf0), int'(e > 9999));
              committed = e;
            end
            busy_cnt = 0;
          end
          if (Busy1) busy_cnt++;
          if (busy_cnt == 40) begin
            n_total++;
            $display("FAIL busy_stuck: got busy 40 cycles expected 17 at %0t", $time);
          end
        end
        prev_busy = Busy1;
        check("scan_lz", int'({Digit1, An1}), exp_pair(shown, 1, slot));
        check("scan_nz", int'({Digit0, An0}), exp_pair(shown, 0, slot));
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (Busy1 && t < 60) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 60) begin
      n_total++;
      $display("FAIL wait_idle: got busy after 60 cycles expected idle at %0t", $time);
    end
  endtask

  task automatic do_load(input int v);
    @(negedge Clk);
    Value = 16'(v);
    Load  = 1'b1;
    sb.push_back(v);
    @(negedge Clk);
    Load = 1'b0;
    wait_idle();
    repeat (24) @(negedge Clk);
  endtask

  initial begin : stimulus
    int v;
    Rst = 1'b1; Load = 1'b0; Value = 16'h0000;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);

    do_load(1234);
    do_load(7);
    do_load(0);
    do_load(9999);
    do_load(10000);
    do_load(42);

    // Load pulses while busy must be ignored
    @(negedge Clk);
    Value = 16'd1234; Load = 1'b1; sb.push_back(1234);
    @(negedge Clk);
    Load = 1'b0;
    repeat (4) @(negedge Clk);
    Value = 16'd5678; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    repeat (10) @(negedge Clk);
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    wait_idle();
    repeat (24) @(negedge Clk);
    do_load(5678);

    // Load held high re-triggers on the first idle cycle
    @(negedge Clk);
    Value = 16'd305; Load = 1'b1;
    sb.push_back(305); sb.push_back(305);
    repeat (19) @(negedge Clk);
    Load = 1'b0;
    wait_idle();
    repeat (24) @(negedge Clk);

    // Reset in the middle of a conversion
    @(negedge Clk);
    Value = 16'd4321; Load = 1'b1; sb.push_back(4321);
    @(negedge Clk);
    Load = 1'b0;
    repeat (7) @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (30) @(negedge Clk);

    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       v = int'($urandom_range(0, 9));
        1:       v = int'($urandom_range(10, 999));
        2:       v = int'($urandom_range(0, 9999));
        default: v = int'($urandom_range(0, 65535));
      endcase
      do_load(v);
    end

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
